// File: rtl/pipe_elastic_delay.sv
// pipe_elastic_delay: STAGE-deep elastic delay line with valid/ready, bubble collapse, flush and occupancy.
// Define PIPE_ELASTIC_DATA_CLEAR_EN to zero data registers whenever their stage is empty.
module pipe_elastic_delay #(
  parameter int SIZE = 8,
  parameter int STAGE = 1,
  localparam int OCC_W = (STAGE == 0) ? 1 : $clog2(STAGE + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [SIZE-1:0]  IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [SIZE-1:0]  OUT_DATA,
  output logic [OCC_W-1:0] OCCUPANCY
);
  if (STAGE == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RESET;
    assign IN_READY = OUT_READY & ~FLUSH;
    assign OUT_VALID = IN_VALID & ~FLUSH;
    assign OUT_DATA = IN_DATA;
    assign OCCUPANCY = '0;
  end else begin : g_pipe
    logic [STAGE:1] v_q, v_d;
    logic [STAGE:0] v_in;
    logic [STAGE+1:1] r;
    logic [SIZE-1:0] d_q [1:STAGE];
    logic [SIZE-1:0] d_d [1:STAGE];
    logic [SIZE-1:0] d_in [0:STAGE-1];
    logic [OCC_W-1:0] occ_q, occ_d;
    assign v_in = {v_q, IN_VALID};
    always_comb begin
      r[STAGE+1] = OUT_READY;
      for (int k = STAGE; k >= 1; k--) r[k] = ~v_q[k] | r[k+1];
      d_in[0] = IN_DATA;
      for (int k = 1; k < STAGE; k++) d_in[k] = d_q[k];
      v_d = v_q;
      d_d = d_q;
      for (int k = 1; k <= STAGE; k++) begin
        if (r[k]) begin
          v_d[k] = v_in[k-1];
          if (v_in[k-1]) d_d[k] = d_in[k-1];
        end
      end
      if (RESET | FLUSH) begin
        v_d = '0;
        d_d = d_q;
      end
`ifdef PIPE_ELASTIC_DATA_CLEAR_EN
      for (int k = 1; k <= STAGE; k++) if (!v_d[k]) d_d[k] = '0;
`endif
      occ_d = '0;
      for (int k = 1; k <= STAGE; k++) occ_d = occ_d + OCC_W'(v_d[k]);
    end
    always_ff @(posedge CLK) begin
      if (RESET) begin
        v_q <= '0;
        occ_q <= '0;
      end else begin
        v_q <= v_d;
        occ_q <= occ_d;
      end
    end
    // data registers carry no reset; d_d already encodes any clearing
    always_ff @(posedge CLK) d_q <= d_d;
    assign IN_READY = r[1] & ~FLUSH;
    assign OUT_VALID = v_q[STAGE] & ~FLUSH;
    assign OUT_DATA = d_q[STAGE];
    assign OCCUPANCY = occ_q;
  end
endmodule

// File: tb/tb_pipe_elastic_delay.sv
// tb_pipe_elastic_delay: directed checks on STAGE=3, STAGE=4 and STAGE=0 instances.
module tb_pipe_elastic_delay;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [7:0] a_in_data = 0, a_out_data;
  logic [1:0] a_occ;
  logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [7:0] b_in_data = 0, b_out_data;
  logic [2:0] b_occ;
  logic c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [7:0] c_in_data = 0, c_out_data;
  logic [0:0] c_occ;

  pipe_elastic_delay #(.SIZE(8), .STAGE(3)) u_a (
    .CLK(clk), .RESET(rst), .FLUSH(a_flush), .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
    .IN_DATA(a_in_data), .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_DATA(a_out_data),
    .OCCUPANCY(a_occ));
  pipe_elastic_delay #(.SIZE(8), .STAGE(4)) u_b (
    .CLK(clk), .RESET(rst), .FLUSH(b_flush), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
    .IN_DATA(b_in_data), .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_DATA(b_out_data),
    .OCCUPANCY(b_occ));
  pipe_elastic_delay #(.SIZE(8), .STAGE(0)) u_c (
    .CLK(clk), .RESET(rst), .FLUSH(c_flush), .IN_VALID(c_in_valid), .IN_READY(c_in_ready),
    .IN_DATA(c_in_data), .OUT_VALID(c_out_valid), .OUT_READY(c_out_ready), .OUT_DATA(c_out_data),
    .OCCUPANCY(c_occ));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [7:0] data);
    a_in_valid = 1;
    a_in_data = data;
    #1;
    check("a_push_ready", a_in_ready, 1);
    tick;
  endtask

  initial begin
    rst = 1;
    tick;
    tick;
    rst = 0;
    #1;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_occ", a_occ, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_occ", b_occ, 0);

    // bubble collapse on STAGE=4 under back-pressure
    b_in_valid = 1; b_in_data = 8'h11; tick;
    b_in_valid = 0; tick;
    tick;
    b_in_valid = 1; b_in_data = 8'h22; tick;
    b_in_valid = 0; #1;
    check("b_occ_two", b_occ, 2);
    check("b_head_11", b_out_data, 8'h11);
    for (int i = 0; i < 4; i++) tick;
    check("b_occ_hold", b_occ, 2);
    check("b_valid_hold", b_out_valid, 1);
    check("b_head_hold", b_out_data, 8'h11);
    check("b_in_ready_bubble", b_in_ready, 1);
    b_out_ready = 1; #1;
    check("b_out_first", b_out_data, 8'h11);
    tick;
    check("b_out_second_v", b_out_valid, 1);
    check("b_out_second", b_out_data, 8'h22);
    tick;
    check("b_drained", b_out_valid, 0);

    // STAGE=0 is a wire
    c_in_valid = 1; c_in_data = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      c_out_ready = i[0];
      #1;
      check("c_out_data", c_out_data, 8'h5A);
      check("c_in_ready", c_in_ready, i[0]);
      check("c_out_valid", c_out_valid, 1);
      check("c_occ", c_occ, 0);
      tick;
    end
    c_flush = 1; #1;
    check("c_flush_valid", c_out_valid, 0);
    check("c_flush_ready", c_in_ready, 0);
    c_flush = 0;

    // streaming with OUT_READY held high
    a_out_ready = 1;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      a_in_valid = cyc < 10;
      a_in_data = 8'(cyc + 1);
      #1;
      if (cyc < 10) check("s_in_ready", a_in_ready, 1);
      if (cyc == 2) check("s_latency", a_out_valid, 0);
      if (cyc >= 3) begin
        check("s_out_valid", a_out_valid, 1);
        check("s_out_data", a_out_data, 32'(cyc - 2));
      end
      if (cyc >= 3 && cyc <= 10) check("s_occ", a_occ, 3);
      tick;
    end
    a_in_valid = 0; #1;
    check("s_empty", a_occ, 0);

    // back-pressure fill and drain in order
    a_out_ready = 0;
    a_push(8'hA1);
    a_push(8'hA2);
    a_push(8'hA3);
    a_in_data = 8'hA4; a_in_valid = 1; #1;
    check("bp_full_ready", a_in_ready, 0);
    check("bp_occ", a_occ, 3);
    check("bp_head", a_out_data, 8'hA1);
    a_out_ready = 1; #1;
    check("bp_release_ready", a_in_ready, 1);
    check("bp_out1", a_out_data, 8'hA1);
    tick;
    a_in_valid = 0; #1;
    check("bp_occ_shift", a_occ, 3);
    check("bp_out2", a_out_data, 8'hA2);
    tick;
    check("bp_out3", a_out_data, 8'hA3);
    tick;
    check("bp_out4", a_out_data, 8'hA4);
    check("bp_out4_v", a_out_valid, 1);
    tick;
    check("bp_done", a_out_valid, 0);

    // flush while full with input pending
    a_out_ready = 0;
    a_push(8'hB1);
    a_push(8'hB2);
    a_push(8'hB3);
    a_flush = 1; a_in_valid = 1; a_in_data = 8'hB4; #1;
    check("fl_in_ready", a_in_ready, 0);
    check("fl_out_valid", a_out_valid, 0);
    check("fl_occ_before", a_occ, 3);
    tick;
    a_flush = 0; a_in_valid = 0; #1;
    check("fl_occ_after", a_occ, 0);
    check("fl_out_valid_after", a_out_valid, 0);
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) tick;
    check("fl_not_captured", a_out_valid, 0);

    // reset together with flush mid-stream
    a_push(8'hC1);
    a_push(8'hC2);
    rst = 1; a_flush = 1; a_in_valid = 1; a_in_data = 8'hC3;
    tick;
    rst = 0; a_flush = 0; a_in_valid = 0; #1;
    check("mr_out_valid", a_out_valid, 0);
    check("mr_occ", a_occ, 0);
    check("mr_in_ready", a_in_ready, 1);
`ifdef PIPE_ELASTIC_DATA_CLEAR_EN
    check("mr_out_data_zero", a_out_data, 0);
`endif
    for (int i = 0; i < 3; i++) tick;
    check("mr_no_ghost", a_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_elastic_delay.md
Name: pipe_elastic_delay

Overview:
- Parametrised successor to the plain multi-stage delay register.
- A STAGE-deep, SIZE-wide delay line with a valid/ready handshake on each side, bubble collapsing, synchronous flush and an occupancy count.
- Sits between Montgomery datapath stages where downstream can stall; STAGE=0 degenerates to a combinational wire.

Parameters:
- SIZE, 8, data width in bits (>=1).
- STAGE, 1, number of register stages (>=0); nominal latency in cycles.
- OCC_W, $clog2(STAGE+1) with a minimum of 1, width of OCCUPANCY (derived localparam, not overridable).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous reset, active-high.
- FLUSH  input  1  synchronous flush: discard all held entries.
- IN_VALID  input  1  upstream presents IN_DATA.
- IN_READY  output  1  block accepts IN_DATA this cycle.
- IN_DATA  input  SIZE  input word.
- OUT_VALID  output  1  OUT_DATA holds a valid entry.
- OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
- OUT_DATA  output  SIZE  output word.
- OCCUPANCY  output  OCC_W  number of valid stages (registered).

Behaviour:
- Per-stage state for k=1..STAGE: valid bit v[k] and data d[k]. Define v[0]=IN_VALID, d[0]=IN_DATA, r[STAGE+1]=OUT_READY.
- Stage ready is combinational: r[k] = ~v[k] | r[k+1]. IN_READY = r[1] & ~FLUSH. The ready chain is combinational through all stages.
- Transfers:
  - Input transfer = IN_VALID & IN_READY.
  - Output transfer = OUT_VALID & OUT_READY.
  - IN_VALID must stay high with IN_DATA stable until accepted. The block guarantees the same on OUT_*.
- Stage update on each edge, when r[k]:
  - v[k] <= v[k-1].
  - d[k] <= d[k-1], but only if v[k-1]; otherwise d[k] holds.
- When ~r[k], the stage holds v[k] and d[k].
- OUT_VALID = v[STAGE] & ~FLUSH. OUT_DATA = d[STAGE].
- Latency and throughput:
  - With OUT_READY=1 permanently: latency exactly STAGE cycles, throughput 1 word/cycle.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled, so up to STAGE words are buffered under back-pressure.
  - Ordering is strictly FIFO. No duplication; no loss except by FLUSH or RESET.
- OCCUPANCY: registered sum of v[1..STAGE] after each edge. Range 0..STAGE. Equals STAGE exactly when full with OUT_READY=0; IN_READY is then 0.
- FLUSH:
  - Next edge clears every v[k] and sets OCCUPANCY to 0.
  - No input or output transfer occurs in a FLUSH cycle, because IN_READY and OUT_VALID are forced 0.
  - Data registers are untouched.
- RESET:
  - Next edge clears every v[k] and sets OCCUPANCY to 0; data registers are untouched.
  - RESET overrides FLUSH and any transfer.
  - Mid-operation reset silently discards all in-flight words.
  - After reset: OUT_VALID=0, OCCUPANCY=0, IN_READY=1 (if FLUSH=0). OUT_DATA is unspecified unless the feature below is on.
- Simultaneous input and output transfer with the line full: the line shifts and OCCUPANCY is unchanged.
- STAGE=0:
  - IN_READY = OUT_READY & ~FLUSH.
  - OUT_VALID = IN_VALID & ~FLUSH.
  - OUT_DATA = IN_DATA.
  - OCCUPANCY = 0. No registers.

Optional Feature:
- Macro: PIPE_ELASTIC_DATA_CLEAR_EN.
- Defined:
  - RESET or FLUSH also zeroes every d[k], so OUT_DATA = 0 after reset.
  - Any stage whose valid goes 0 on an edge also loads d[k] = 0, so OUT_DATA = 0 whenever OUT_VALID = 0. Used for side-channel hygiene and clean waveforms.
- Undefined:
  - Data registers have no reset (smaller, faster).
  - OUT_DATA is don't-care while OUT_VALID = 0.

Test Plan:
- STAGE=3, SIZE=8, OUT_READY=1: drive 0x01..0x0A on 10 consecutive cycles -> OUT_DATA shows 0x01..0x0A on cycles 3..12, OUT_VALID continuous, OCCUPANCY steady at 3.
- STAGE=3, OUT_READY=0: push 0xA1, 0xA2, 0xA3, 0xA4 -> first three accepted, IN_READY=0 on the 4th, OCCUPANCY=3. Raise OUT_READY -> outputs 0xA1, 0xA2, 0xA3, 0xA4 in order, no loss.
- Bubble collapse, STAGE=4: inject 0x11, idle 2 cycles, inject 0x22, OUT_READY=0 -> OCCUPANCY=2, and 0x11 sits in stage 4 with 0x22 in stage 3 after 4 more cycles.
- FLUSH with OCCUPANCY=3 and IN_VALID=1 -> IN_READY=0 and OUT_VALID=0 in that cycle; next cycle OCCUPANCY=0 and OUT_VALID=0. The flushed input is not captured.
- RESET asserted together with FLUSH and IN_VALID mid-stream -> next cycle OUT_VALID=0, OCCUPANCY=0, IN_READY=1. With PIPE_ELASTIC_DATA_CLEAR_EN also check OUT_DATA=0x00.
- STAGE=0: IN_DATA=0x5A, IN_VALID=1, OUT_READY toggling -> OUT_DATA=0x5A in the same cycle, and IN_READY mirrors OUT_READY.
